game_fsm_multi: RTL and testbench

GAME_FSM_MULTI -- requirements
Module: game_fsm_multi

---
 rtl/game_fsm_multi.sv | 174 +++++++++++++++++
 tb/tb_game_fsm_multi.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/game_fsm_multi.sv
// Start-button / multi-target scoring game controller with lives and a life-lost pause.
// Define GAME_FSM_PAUSE_EN to add a PAUSED state toggled by keycode 8'h29 during play.
module game_fsm_multi #(
    parameter int         NUM_TARGETS  = 3,
    parameter int         SCORE_W      = 11,
    parameter int         WIN_SCORE    = 3,
    parameter int         LIVES        = 3,
    parameter int         PAUSE_CYCLES = 60,
    parameter logic [9:0] BTN_X        = 10'd320,
    parameter logic [9:0] BTN_Y        = 10'd320,
    parameter logic [9:0] BTN_HW       = 10'd40,
    parameter logic [9:0] BTN_HH       = 10'd40,
    parameter logic [7:0] RESTART_KEY  = 8'h28
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   leftButton,
    input  logic [9:0]             cursorX,
    input  logic [9:0]             cursorY,
    input  logic [7:0]             key,
    input  logic                   caught,
    input  logic [NUM_TARGETS-1:0] scoring,
    output logic                   game_start,
    output logic                   ready,
    output logic                   won,
    output logic                   lost,
    output logic [SCORE_W-1:0]     totalscore,
    output logic [3:0]             hextotal,
    output logic [3:0]             hextotal2,
    output logic [3:0]             lives_left,
    output logic [NUM_TARGETS-1:0] target_done
);

    localparam int                 CNT_W     = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PAUSE_CYCLES - 1);
    localparam int                 SUM_W     = SCORE_W + 5;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
    // Button bounds widened to 11 bits; a half-extent larger than the centre clamps to 0.
    localparam logic [10:0] X_LO = (BTN_HW > BTN_X) ? 11'd0 : 11'(BTN_X - BTN_HW);
    localparam logic [10:0] Y_LO = (BTN_HH > BTN_Y) ? 11'd0 : 11'(BTN_Y - BTN_HH);
    localparam logic [10:0] X_HI = 11'(BTN_X) + 11'(BTN_HW);
    localparam logic [10:0] Y_HI = 11'(BTN_Y) + 11'(BTN_HH);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_PLAY, S_LIFE_LOST, S_WIN, S_LOSE
`ifdef GAME_FSM_PAUSE_EN
        , S_PAUSED
`endif
    } state_t;

    state_t               state;
    logic                 btn_prev;
    logic                 click;
    logic [CNT_W-1:0]     pause_cnt;
    logic [NUM_TARGETS-1:0] hits;
    logic [4:0]           hit_cnt;
    logic [SUM_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_nxt;
    logic [6:0]           bcd_sum;
    logic [6:0]           bcd_sat;

`ifdef GAME_FSM_PAUSE_EN
    logic [7:0] key_prev;
    logic       pause_hit;
    // Toggle only on a fresh press so a held key cannot bounce in and out of PAUSED.
    assign pause_hit = (key == 8'h29) && (key_prev != 8'h29);
`endif

    assign click = leftButton && !btn_prev
                && ({1'b0, cursorX} >= X_LO) && ({1'b0, cursorX} < X_HI)
                && ({1'b0, cursorY} >= Y_LO) && ({1'b0, cursorY} < Y_HI);

    always_comb begin
        hits    = scoring & ~target_done;
        hit_cnt = '0;
        for (int i = 0; i < NUM_TARGETS; i++)
            hit_cnt = hit_cnt + 5'(hits[i]);
        score_sum = SUM_W'(totalscore) + SUM_W'(hit_cnt);
        score_nxt = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
        // BCD view tracks the same increments but saturates at 99 on its own.
        bcd_sum   = 7'(hextotal2) * 7'd10 + 7'(hextotal) + 7'(hit_cnt);
        bcd_sat   = (bcd_sum > 7'd99) ? 7'd99 : bcd_sum;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            btn_prev    <= 1'b0;
            pause_cnt   <= '0;
            totalscore  <= '0;
            hextotal    <= '0;
            hextotal2   <= '0;
            lives_left  <= 4'(LIVES);
            target_done <= '0;
            game_start  <= 1'b1;
            ready       <= 1'b0;
            won         <= 1'b0;
            lost        <= 1'b0;
`ifdef GAME_FSM_PAUSE_EN
            key_prev    <= '0;
`endif
        end else begin
            btn_prev <= leftButton;
            ready    <= 1'b0;
`ifdef GAME_FSM_PAUSE_EN
            key_prev <= key;
`endif
            case (state)
                S_IDLE: if (click) begin
                    state      <= S_ARM;
                    game_start <= 1'b0;
                end
                S_ARM: begin
                    state       <= S_PLAY;
                    ready       <= 1'b1;
                    totalscore  <= '0;
                    hextotal    <= '0;
                    hextotal2   <= '0;
                    target_done <= '0;
                    lives_left  <= 4'(LIVES);
                end
                S_PLAY:
`ifdef GAME_FSM_PAUSE_EN
                if (pause_hit) state <= S_PAUSED; else
`endif
                begin
                    totalscore  <= score_nxt;
                    hextotal    <= 4'(bcd_sat % 7'd10);
                    hextotal2   <= 4'(bcd_sat / 7'd10);
                    target_done <= target_done | scoring;
                    // A win in the same cycle as a catch wins and keeps the life.
                    if (score_nxt >= WIN_S) begin
                        state <= S_WIN;
                        won   <= 1'b1;
                    end else if (caught) begin
                        lives_left <= lives_left - 4'd1;
                        if (lives_left == 4'd1) begin
                            state <= S_LOSE;
                            lost  <= 1'b1;
                        end else begin
                            state     <= S_LIFE_LOST;
                            pause_cnt <= '0;
                        end
                    end
                end
                S_LIFE_LOST: begin
                    if (pause_cnt == CNT_LAST) begin
                        state     <= S_PLAY;
                        pause_cnt <= '0;
                    end else begin
                        pause_cnt <= pause_cnt + 1'b1;
                    end
                end
                S_WIN, S_LOSE: if (key == RESTART_KEY) begin
                    state      <= S_IDLE;
                    won        <= 1'b0;
                    lost       <= 1'b0;
                    game_start <= 1'b1;
                end
`ifdef GAME_FSM_PAUSE_EN
                S_PAUSED: if (pause_hit) state <= S_PLAY;
`endif
                default: begin
                    state      <= S_IDLE;
                    game_start <= 1'b1;
                    won        <= 1'b0;
                    lost       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_fsm_multi.sv
// Bench for game_fsm_multi: point-count model checked every cycle plus literal spot checks.
module tb_game_fsm_multi;
    localparam int NT = 3;
    localparam int SW = 11;
    localparam int WIN_PTS = 3;
    localparam int LV = 3;
    localparam int PC = 60;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b1;
    logic          leftButton = 1'b0;
    logic [9:0]    cursorX = '0;
    logic [9:0]    cursorY = '0;
    logic [7:0]    key = '0;
    logic          caught = 1'b0;
    logic [NT-1:0] scoring = '0;
    logic          game_start, ready, won, lost;
    logic [SW-1:0] totalscore;
    logic [3:0]    hextotal, hextotal2, lives_left;
    logic [NT-1:0] target_done;

    always #5 Clk = ~Clk;

    game_fsm_multi #(.NUM_TARGETS(NT), .SCORE_W(SW), .WIN_SCORE(WIN_PTS), .LIVES(LV),
                     .PAUSE_CYCLES(PC)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .leftButton(leftButton), .cursorX(cursorX),
        .cursorY(cursorY), .key(key), .caught(caught), .scoring(scoring),
        .game_start(game_start), .ready(ready), .won(won), .lost(lost),
        .totalscore(totalscore), .hextotal(hextotal), .hextotal2(hextotal2),
        .lives_left(lives_left), .target_done(target_done)
    );

    int errs = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            if (errs <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: game phase by name, raw points earned (saturation applied only when viewed).
    string     m_st;
    int        m_pts, m_lives, m_wait;
    bit [NT-1:0] m_done;
    bit        m_ready, m_prev;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_st <= "IDLE"; m_pts <= 0; m_lives <= LV; m_wait <= 0;
            m_done <= '0; m_ready <= 1'b0; m_prev <= 1'b0;
        end else begin
            automatic bit click = leftButton && !m_prev
                && int'(cursorX) >= 280 && int'(cursorX) < 360
                && int'(cursorY) >= 280 && int'(cursorY) < 360;
            automatic int n = 0;
            m_prev  <= leftButton;
            m_ready <= 1'b0;
            if (m_st == "IDLE") begin
                if (click) m_st <= "ARM";
            end else if (m_st == "ARM") begin
                m_st <= "PLAY"; m_ready <= 1'b1; m_pts <= 0; m_done <= '0; m_lives <= LV;
            end else if (m_st == "PLAY") begin
                for (int i = 0; i < NT; i++) if (scoring[i] && !m_done[i]) n++;
                m_pts  <= m_pts + n;
                m_done <= m_done | scoring;
                if (m_pts + n >= WIN_PTS) m_st <= "WIN";
                else if (caught) begin
                    m_lives <= m_lives - 1;
                    if (m_lives == 1) m_st <= "LOSE";
                    else begin m_st <= "LIFE_LOST"; m_wait <= PC; end
                end
            end else if (m_st == "LIFE_LOST") begin
                m_wait <= m_wait - 1;
                if (m_wait == 1) m_st <= "PLAY";
            end else begin
                if (key == 8'h28) m_st <= "IDLE";
            end
        end
    end

    always @(negedge Clk) if (chk_en) begin
        automatic int sat = (m_pts > 2047) ? 2047 : m_pts;
        automatic int b   = (m_pts > 99) ? 99 : m_pts;
        chk("game_start", int'(game_start), int'(m_st == "IDLE"));
        chk("ready", int'(ready), int'(m_ready));
        chk("won", int'(won), int'(m_st == "WIN"));
        chk("lost", int'(lost), int'(m_st == "LOSE"));
        chk("totalscore", int'(totalscore), sat);
        chk("hextotal", int'(hextotal), b % 10);
        chk("hextotal2", int'(hextotal2), b / 10);
        chk("lives_left", int'(lives_left), m_lives);
        chk("target_done", int'(target_done), int'(m_done));
    end

    task automatic cyc(input int n);
        repeat (n) begin @(negedge Clk); #1; end
    endtask

    task automatic click_at(input int x, input int y);
        cursorX = 10'(x); cursorY = 10'(y);
        leftButton = 1'b1; cyc(1);
        leftButton = 1'b0; cyc(1);
    endtask

    initial begin
        #2 Reset_n = 1'b0;
        chk_en = 1'b1;
        cyc(2);
        chk("rst_game_start", int'(game_start), 1);
        chk("rst_totalscore", int'(totalscore), 0);
        chk("rst_lives", int'(lives_left), 3);
        chk("rst_ready", int'(ready), 0);
        Reset_n = 1'b1;
        cyc(1);

        // Exclusive right/bottom bounds: no click
        click_at(360, 320);
        chk("xbound_idle", int'(game_start), 1);
        click_at(320, 360);
        chk("ybound_idle", int'(game_start), 1);

        // Game A: all three targets at once wins
        click_at(320, 320);
        chk("A_ready", int'(ready), 1);
        chk("A_lives", int'(lives_left), 3);
        cyc(1);
        chk("A_ready_pulse", int'(ready), 0);
        scoring = 3'b111; cyc(1); scoring = '0;
        chk("A_total", int'(totalscore), 3);
        chk("A_hex", int'(hextotal), 3);
        chk("A_won", int'(won), 1);
        key = 8'h28; cyc(1); key = '0;
        chk("A_idle", int'(game_start), 1);
        chk("A_score_held", int'(totalscore), 3);

        // Game B: one-shot channel, lives lost through pauses, then LOSE
        click_at(280, 280);
        chk("B_cleared", int'(totalscore), 0);
        scoring = 3'b001; cyc(10); scoring = '0; cyc(1);
        chk("B_total1", int'(totalscore), 1);
        chk("B_done", int'(target_done), 1);
        caught = 1'b1; cyc(1); caught = 1'b0;
        chk("B_lives2", int'(lives_left), 2);
        scoring = 3'b010; cyc(59); scoring = '0;
        chk("B_pause_ignores", int'(totalscore), 1);
        cyc(1);
        caught = 1'b1; cyc(1); caught = 1'b0;
        chk("B_lives1", int'(lives_left), 1);
        cyc(20); caught = 1'b1; cyc(1); caught = 1'b0;
        chk("B_pause_catch", int'(lives_left), 1);
        cyc(39);
        caught = 1'b1; cyc(1); caught = 1'b0;
        chk("B_lost", int'(lost), 1);
        chk("B_lives0", int'(lives_left), 0);
        key = 8'h28; cyc(1); key = '0;
        chk("B_idle", int'(game_start), 1);

        // Game C: win and catch together
        click_at(320, 320);
        scoring = 3'b111; caught = 1'b1; cyc(1); scoring = '0; caught = 1'b0;
        chk("C_won", int'(won), 1);
        chk("C_lives", int'(lives_left), 3);
        key = 8'h28; cyc(1); key = '0;

        // Game D: reset mid-PLAY and mid-LIFE_LOST
        click_at(320, 320);
        scoring = 3'b001; cyc(1); scoring = '0; cyc(2);
        Reset_n = 1'b0; #1;
        chk("D_async_score", int'(totalscore), 0);
        chk("D_async_idle", int'(game_start), 1);
        cyc(1); Reset_n = 1'b1; cyc(3);
        chk("D_stays_idle", int'(game_start), 1);
        click_at(320, 320);
        caught = 1'b1; cyc(1); caught = 1'b0; cyc(5);
        Reset_n = 1'b0; #1;
        chk("D_lives_reset", int'(lives_left), 3);
        cyc(1); Reset_n = 1'b1; cyc(3);
        chk("D_idle2", int'(game_start), 1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
